// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencing controller: sequencer FSM state
// encoding, register word offsets (addr[3:2]), CTRL bit positions, the AXI
// OKAY response code and a byte-strobe merge helper for register writes.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    // Word offsets, i.e. byte address bits [3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_DIR  = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Merge new data into an existing 32-bit register, byte lane by byte lane
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_seq_core.sv
// ---------------------------------------------------------------------------
// led_seq_core
// Sequencer engine: IDLE/LOAD/RUN state machine, tick counter, rotator and
// 16-bit step counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable (CTRL.EN)
//   mode       : 0 hold pattern, 1 rotate (CTRL.MODE)
//   dir        : 0 rotate left, 1 rotate right (CTRL.DIR)
//   period     : clocks per step, 0 behaves as 1
//   pattern    : base pattern loaded in LOAD
//   reload     : one-cycle pulse after a PATTERN/PERIOD write; restarts RUN
//   led_out    : registered LED vector (0 in IDLE)
//   step_cnt   : number of rotation steps since the last load (wraps)
// ---------------------------------------------------------------------------
module led_seq_core
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                dir,
    input  logic [31:0]         period,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                reload,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [15:0]         step_cnt
);

    seq_state_e          state_r;
    seq_state_e          state_nxt_s;
    logic [NUM_LEDS-1:0] shift_r;
    logic [NUM_LEDS-1:0] shift_nxt_s;
    logic [NUM_LEDS-1:0] rot_s;
    logic [NUM_LEDS-1:0] led_r;
    logic [NUM_LEDS-1:0] led_nxt_s;
    logic [31:0]         tick_r;
    logic [31:0]         tick_nxt_s;
    logic [31:0]         period_m1_s;
    logic [15:0]         step_r;
    logic [15:0]         step_nxt_s;

    // Terminal tick count; a programmed period of 0 steps every clock like 1
    assign period_m1_s = (period == 32'd0) ? 32'd0 : (period - 32'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; disabling always wins over a pending reload
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_nxt_s = ST_LOAD;
                else    state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (en) state_nxt_s = ST_RUN;
                else    state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!en)         state_nxt_s = ST_IDLE;
                else if (reload) state_nxt_s = ST_LOAD;
                else             state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // One-position rotation with end-around wrap; works for any width >= 1
    always_comb begin
        rot_s = shift_r;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (dir) rot_s[i] = shift_r[(i == NUM_LEDS-1) ? 0 : i+1];
            else     rot_s[i] = shift_r[(i == 0) ? NUM_LEDS-1 : i-1];
        end
    end

    // Datapath next values; a step only happens while staying in RUN, so a
    // reload or disable cycle never advances the sequence
    always_comb begin
        shift_nxt_s = shift_r;
        tick_nxt_s  = tick_r;
        step_nxt_s  = step_r;
        case (state_r)
            ST_IDLE: begin
                shift_nxt_s = {NUM_LEDS{1'b0}};
                tick_nxt_s  = 32'd0;
            end
            ST_LOAD: begin
                shift_nxt_s = pattern;
                tick_nxt_s  = 32'd0;
                step_nxt_s  = 16'd0;
            end
            ST_RUN: begin
                if ((state_nxt_s == ST_RUN) && mode) begin
                    if (tick_r >= period_m1_s) begin
                        tick_nxt_s  = 32'd0;
                        shift_nxt_s = rot_s;
                        step_nxt_s  = step_r + 16'd1;
                    end else begin
                        tick_nxt_s  = tick_r + 32'd1;
                    end
                end else begin
                    tick_nxt_s  = tick_r;
                end
            end
            default: begin
                shift_nxt_s = {NUM_LEDS{1'b0}};
                tick_nxt_s  = 32'd0;
                step_nxt_s  = 16'd0;
            end
        endcase
        // led_out is registered, so derive it from the upcoming state
        led_nxt_s = (state_nxt_s == ST_IDLE) ? {NUM_LEDS{1'b0}} : shift_nxt_s;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {NUM_LEDS{1'b0}};
            tick_r  <= 32'd0;
            step_r  <= 16'd0;
            led_r   <= {NUM_LEDS{1'b0}};
        end else begin
            shift_r <= shift_nxt_s;
            tick_r  <= tick_nxt_s;
            step_r  <= step_nxt_s;
            led_r   <= led_nxt_s;
        end
    end

    assign led_out  = led_r;
    assign step_cnt = step_r;

endmodule

// File: rtl/led_sequencer_ctrl.sv
// ---------------------------------------------------------------------------
// led_sequencer_ctrl
// AXI4-Lite slave with a four-word register file (CTRL, PERIOD, PATTERN,
// STATUS) driving the led_seq_core sequencer.
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*          : write address, data and response
//   s00_axi_ar* / r*               : read address and data
//   led_out                        : LED vector from the sequencer
// One write and one read may be in flight at once; each handshake is a
// one-cycle ready pulse followed by a response held until accepted. A read
// captured on the same edge as a write returns the pre-write value.
// ---------------------------------------------------------------------------
module led_sequencer_ctrl
    import led_seq_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_LEDS-1:0]             led_out
);

    logic                aw_ready_r;
    logic                w_ready_r;
    logic                b_valid_r;
    logic                ar_ready_r;
    logic                r_valid_r;
    logic [31:0]         r_data_r;
    logic [2:0]          ctrl_r;
    logic [31:0]         period_r;
    logic [31:0]         pattern_r;
    logic                reload_r;
    logic [1:0]          wr_addr_s;
    logic [1:0]          rd_addr_s;
    logic [31:0]         rd_mux_s;
    logic [31:0]         led_ext_s;
    logic [31:0]         status_s;
    logic [NUM_LEDS-1:0] led_s;
    logic [15:0]         step_s;
    logic                unused_s;

    assign wr_addr_s = s00_axi_awaddr[3:2];
    assign rd_addr_s = s00_axi_araddr[3:2];

    // Protection bits and byte offsets carry no meaning for this block
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    // Write channel and register file; no new write while a response is pending
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            reload_r   <= 1'b0;
            ctrl_r     <= 3'd0;
            period_r   <= 32'd0;
            pattern_r  <= 32'd0;
        end else begin
            reload_r <= 1'b0;
            if (b_valid_r) begin
                if (s00_axi_bready) begin
                    b_valid_r <= 1'b0;
                end
            end else if (aw_ready_r) begin
                aw_ready_r <= 1'b0;
                w_ready_r  <= 1'b0;
                if (s00_axi_awvalid && s00_axi_wvalid) begin
                    b_valid_r <= 1'b1;
                    case (wr_addr_s)
                        REG_CTRL: begin
                            if (s00_axi_wstrb[0]) ctrl_r <= s00_axi_wdata[2:0];
                        end
                        REG_PERIOD: begin
                            period_r <= apply_wstrb(period_r, s00_axi_wdata, s00_axi_wstrb);
                            reload_r <= 1'b1;
                        end
                        REG_PATTERN: begin
                            pattern_r <= apply_wstrb(pattern_r, s00_axi_wdata, s00_axi_wstrb);
                            reload_r  <= 1'b1;
                        end
                        default: begin
                            // STATUS is read-only: the write is acknowledged and dropped
                            reload_r <= 1'b0;
                        end
                    endcase
                end
            end else if (s00_axi_awvalid && s00_axi_wvalid) begin
                aw_ready_r <= 1'b1;
                w_ready_r  <= 1'b1;
            end
        end
    end

    // STATUS word: LED image in the low bits, step counter in [31:16]
    always_comb begin
        led_ext_s                 = 32'd0;
        led_ext_s[NUM_LEDS-1:0]   = led_s;
        status_s                  = {step_s, 16'd0} | led_ext_s;
    end

    // Read data selection
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_addr_s)
            REG_CTRL:    rd_mux_s = {29'd0, ctrl_r};
            REG_PERIOD:  rd_mux_s = period_r;
            REG_PATTERN: rd_mux_s = pattern_r;
            REG_STATUS:  rd_mux_s = status_s;
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Read channel: arready pulse, then data captured and held until rready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_data_r   <= 32'd0;
        end else begin
            if (r_valid_r) begin
                if (s00_axi_rready) begin
                    r_valid_r <= 1'b0;
                end
            end else if (ar_ready_r) begin
                ar_ready_r <= 1'b0;
                if (s00_axi_arvalid) begin
                    r_valid_r <= 1'b1;
                    r_data_r  <= rd_mux_s;
                end
            end else if (s00_axi_arvalid) begin
                ar_ready_r <= 1'b1;
            end
        end
    end

    led_seq_core #(
        .NUM_LEDS (NUM_LEDS)
    ) u_core (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .en       (ctrl_r[CTRL_EN]),
        .mode     (ctrl_r[CTRL_MODE]),
        .dir      (ctrl_r[CTRL_DIR]),
        .period   (period_r),
        .pattern  (pattern_r[NUM_LEDS-1:0]),
        .reload   (reload_r),
        .led_out  (led_s),
        .step_cnt (step_s)
    );

    assign s00_axi_awready = aw_ready_r;
    assign s00_axi_wready  = w_ready_r;
    assign s00_axi_bvalid  = b_valid_r;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = ar_ready_r;
    assign s00_axi_rvalid  = r_valid_r;
    assign s00_axi_rdata   = r_data_r;
    assign s00_axi_rresp   = RESP_OKAY;
    assign led_out         = led_s;

endmodule
